// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
// Contents: baud_rate and parity_type encodings, receiver FSM state type,
// the oversample ratio, and helpers for the baud divisor and parity.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  // 2'b11 is also treated as "no parity".
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clocks per oversample tick for a given baud code (integer truncation).
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [1:0]  code);
    int unsigned baud;
    case (code)
      BAUD_2400: baud = 2400;
      BAUD_4800: baud = 4800;
      BAUD_9600: baud = 9600;
      default:   baud = 19200;
    endcase
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

  function automatic logic par_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  // Parity bit the sender should have put on the line for this byte.
  function automatic logic par_expected(input logic [1:0] ptype,
                                        input logic [7:0] data);
    return (ptype == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO for the UART receiver.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en_i       push wr_data_i (ignored when full)
//   wr_data_i     byte to push
//   rd_en_i       pop the head (ignored when empty)
//   rd_data_o     current head, forced to 0 while empty
//   full_o        DEPTH entries held
//   empty_o       no entries held
`timescale 1ns/1ps
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic            do_wr, do_rd;

  assign full_o    = (count_q == (ADDR+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // A pop on an empty FIFO is dropped even if a write lands the same cycle.
  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the read mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1/8O1/8E1 frame recovery, LSB first,
// with parity/stop checking and a FWFT receive FIFO.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rx            serial line (asynchronous, idle high)
//   baud_rate     00=2400 01=4800 10=9600 11=19200
//   parity_type   00/11=none 01=odd 10=even
//   rd_en         pop one byte from the FIFO
//   data_out      FIFO head, valid while !fifo_empty
//   fifo_empty    FIFO holds no bytes
//   active        start-bit confirm until stop-bit sample
//   parity_err    one-cycle pulse on parity mismatch
//   frame_err     one-cycle pulse on low stop bit
//   overrun       one-cycle pulse when a good byte met a full FIFO
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_ADDR  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       fifo_empty,
  output logic       active,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV_2400  = baud_div(CLK_FREQ, BAUD_2400);
  localparam int unsigned DIV_4800  = baud_div(CLK_FREQ, BAUD_4800);
  localparam int unsigned DIV_9600  = baud_div(CLK_FREQ, BAUD_9600);
  localparam int unsigned DIV_19200 = baud_div(CLK_FREQ, BAUD_19200);
  localparam int          DIV_W     = (DIV_2400 < 1) ? 1 : $clog2(DIV_2400 + 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       par_type_q, par_type_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             active_q, active_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             tick;
  logic             fifo_wr;
  logic             fifo_full;

  assign tick = (div_cnt_q == div_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q;
    os_cnt_d     = os_cnt_q;
    bit_idx_d    = bit_idx_q;
    par_type_d   = par_type_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    active_d     = active_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    fifo_wr      = 1'b0;

    // The divisor is only reloaded while idle so a baud change never
    // disturbs a frame in flight; the tick phase starts fresh per frame.
    if (state_q == ST_IDLE) begin
      div_cnt_d = '0;
      case (baud_rate)
        BAUD_2400: div_d = DIV_W'(DIV_2400);
        BAUD_4800: div_d = DIV_W'(DIV_4800);
        BAUD_9600: div_d = DIV_W'(DIV_9600);
        default:   div_d = DIV_W'(DIV_19200);
      endcase
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d  = ST_START;
          os_cnt_d = '0;
        end
      end
      ST_START: begin
        // Eighth tick lands mid start bit; a high line there was a glitch.
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d = '0;
            if (!rx_s_q) begin
              state_d    = ST_DATA;
              active_d   = 1'b1;
              bit_idx_d  = '0;
              par_type_d = parity_type;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == 4'd15) begin
            shift_d[bit_idx_q] = rx_s_q;
            bit_idx_d          = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7)
              state_d = par_enabled(par_type_q) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == 4'd15) begin
            par_bit_d = rx_s_q;
            state_d   = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Decide at mid stop bit and return to idle immediately so the next
        // start edge can be caught even with no gap between frames.
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == 4'd15) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            if (!rx_s_q)
              frame_err_d = 1'b1;
            else if (par_enabled(par_type_q) &&
                     (par_bit_q != par_expected(par_type_q, shift_q)))
              parity_err_d = 1'b1;
            else if (fifo_full)
              overrun_d = 1'b1;
            else
              fifo_wr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= DIV_W'(DIV_2400);
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      par_type_q   <= PAR_NONE;
      active_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      par_type_q   <= par_type_d;
      active_q     <= active_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .ADDR (FIFO_ADDR)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (fifo_wr),
    .wr_data_i(shift_q),
    .rd_en_i  (rd_en),
    .rd_data_o(data_out),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign active     = active_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 1_228_800;
  localparam int BIT_9600 = 128;
  localparam int BIT_2400 = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       rd_en;
  logic [7:0] data_out;
  logic       fifo_empty;
  logic       active;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .FIFO_DEPTH(16),
    .FIFO_ADDR (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_rate  (baud_rate),
    .parity_type(parity_type),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .fifo_empty (fifo_empty),
    .active     (active),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of bytes the FIFO should hold, plus expected pulse totals.
  logic [7:0] exp_q[$];
  int exp_perr = 0, exp_ferr = 0, exp_ovr = 0;

  // Observed pulse-cycle totals and the state one clk after each stop sample.
  int perr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, act_cycles = 0, fall_seen = 0;
  logic       fall_empty = 1'b1;
  logic [7:0] fall_data  = 8'h00;
  logic       act_prev   = 1'b0;

  always @(negedge clk) begin
    perr_cnt   += int'(parity_err);
    ferr_cnt   += int'(frame_err);
    ovr_cnt    += int'(overrun);
    act_cycles += int'(active);
    if (act_prev && !active) begin
      fall_seen++;
      fall_empty = fifo_empty;
      fall_data  = data_out;
    end
    act_prev = active;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pmode,
                            input bit flip, input logic stopb, input int bclk);
    logic has_par;
    logic pbit;
    has_par = (pmode == PAR_ODD) || (pmode == PAR_EVEN);
    pbit    = (pmode == PAR_ODD) ? ~(^d) : ^d;
    if (flip) pbit = ~pbit;
    parity_type = pmode;
    rx = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(bclk);
    end
    if (has_par) begin
      rx = pbit;
      wait_clks(bclk);
    end
    rx = stopb;
    wait_clks(bclk);
    rx = 1'b1;
    if (!stopb)                 exp_ferr++;
    else if (has_par && flip)   exp_perr++;
    else if (exp_q.size() >= 16) exp_ovr++;
    else                        exp_q.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_nonempty"}, 32'(fifo_empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(data_out), 32'(e));
    end
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_parity_err"}, perr_cnt, exp_perr);
    check({tag, "_frame_err"},  ferr_cnt, exp_ferr);
    check({tag, "_overrun"},    ovr_cnt,  exp_ovr);
  endtask

  initial begin
    int a0, f0;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
    baud_rate = BAUD_9600; parity_type = PAR_NONE;
    wait_clks(3);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_fifo_empty", 32'(fifo_empty), 32'h1);
    check("rst_active",     32'(active),     32'h0);
    check("rst_errs",       32'({parity_err, frame_err, overrun}), 32'h0);
    rst = 1'b0;
    wait_clks(20);

    // 1: plain 8N1 byte at 9600
    a0 = act_cycles; f0 = fall_seen;
    send_frame(8'hA5, PAR_NONE, 0, 1'b1, BIT_9600);
    wait_clks(4);
    check("t1_fall_seen", fall_seen - f0, 1);
    check("t1_empty_after_stop", 32'(fall_empty), 32'h0);
    check("t1_data_after_stop",  32'(fall_data),  32'hA5);
    check("t1_active_len_ok", 32'((act_cycles - a0) >= 1150 && (act_cycles - a0) <= 1154), 32'h1);
    check_flags("t1");
    pop_check("t1_pop");
    check("t1_empty_end", 32'(fifo_empty), 32'h1);

    // 2: even then odd parity, good and bad parity bits
    send_frame(8'h03, PAR_EVEN, 0, 1'b1, BIT_9600);
    wait_clks(4);
    send_frame(8'h03, PAR_EVEN, 1, 1'b1, BIT_9600);
    wait_clks(4);
    send_frame(8'h03, PAR_ODD, 0, 1'b1, BIT_9600);
    wait_clks(4);
    send_frame(8'h03, PAR_ODD, 1, 1'b1, BIT_9600);
    wait_clks(4);
    check_flags("t2");
    pop_check("t2_pop_even");
    pop_check("t2_pop_odd");
    check("t2_empty_end", 32'(fifo_empty), 32'h1);

    // 3: low stop bit, then a good frame
    send_frame(8'h5A, PAR_NONE, 0, 1'b0, BIT_9600);
    wait_clks(200);
    check_flags("t3_bad");
    check("t3_empty_after_ferr", 32'(fifo_empty), 32'h1);
    send_frame(8'h11, PAR_NONE, 0, 1'b1, BIT_9600);
    wait_clks(4);
    check_flags("t3_good");
    pop_check("t3_pop");

    // 4: short low glitch while idle
    a0 = act_cycles;
    rx = 1'b0;
    wait_clks(40);
    rx = 1'b1;
    wait_clks(200);
    check("t4_active_never", act_cycles - a0, 0);
    check_flags("t4");
    check("t4_empty", 32'(fifo_empty), 32'h1);

    // 5: 17 back-to-back frames, FIFO overflows on the last
    for (int i = 0; i <= 16; i++) send_frame(8'(i), PAR_NONE, 0, 1'b1, BIT_9600);
    wait_clks(4);
    check_flags("t5");
    for (int i = 0; i < 16; i++) pop_check("t5_pop");
    check("t5_empty_end", 32'(fifo_empty), 32'h1);

    // 6: reset in the middle of bit 4, then a 2400-baud frame
    send_frame(8'h77, PAR_NONE, 0, 1'b1, BIT_9600);
    wait_clks(4);
    rx = 1'b0;
    wait_clks(BIT_9600);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_clks(BIT_9600);
    end
    rx = 1'b1;
    wait_clks(BIT_9600 / 2);
    check("t6_active_midframe", 32'(active), 32'h1);
    rst = 1'b1;
    #2;
    check("t6_rst_data_out",   32'(data_out),   32'h00);
    check("t6_rst_fifo_empty", 32'(fifo_empty), 32'h1);
    check("t6_rst_active",     32'(active),     32'h0);
    exp_q.delete();
    wait_clks(3);
    check("t6_rst_errs", 32'({parity_err, frame_err, overrun}), 32'h0);
    rst = 1'b0;
    baud_rate = BAUD_2400;
    wait_clks(50);
    send_frame(8'hC3, PAR_NONE, 0, 1'b1, BIT_2400);
    wait_clks(4);
    check_flags("t6");
    pop_check("t6_pop");
    check("t6_empty_end", 32'(fifo_empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
